// File: rtl/log_mem_ctrl_pkg.sv
// Shared constants and FSM encoding for the data-log capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: NB_LOG_ADDR / NB_LOG_DATA (also used by the command decoder's
// address field) and the capture FSM state type.
package log_mem_ctrl_pkg;

  localparam int NB_LOG_ADDR = 15;
  localparam int NB_LOG_DATA = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } log_state_t;

endpackage

// File: rtl/log_mem_ctrl_if.sv
// Bundle of command, sample and readback signals between the
// command/file-register side (master) and log_mem_ctrl (slave).
// Latency: n/a (wires only).
// Backpressure: none; samples are qualified by i_valid only.
// Ports: i_run, i_read, i_rd_addr, i_data, i_valid toward the controller;
//        o_mem_full, o_capturing, o_wr_count, o_data back from it.
interface log_mem_ctrl_if
  import log_mem_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_LOG_DATA,
  parameter int NB_ADDR = NB_LOG_ADDR
) ();

  logic               i_run;
  logic               i_read;
  logic [NB_ADDR-1:0] i_rd_addr;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_mem_full;
  logic               o_capturing;
  logic [NB_ADDR:0]   o_wr_count;
  logic [NB_DATA-1:0] o_data;

  modport master (
    output i_run, i_read, i_rd_addr, i_data, i_valid,
    input  o_mem_full, o_capturing, o_wr_count, o_data
  );

  modport slave (
    input  i_run, i_read, i_rd_addr, i_data, i_valid,
    output o_mem_full, o_capturing, o_wr_count, o_data
  );

endinterface

// File: rtl/log_ram.sv
// Simple dual-port log RAM: one write port, one registered read port.
// Latency: write visible after its edge; read data 1 cycle after raddr/re.
// Backpressure: none; rdata holds when re is low.
// Ports: clock, reset (read register only), we/waddr/wdata, re/raddr/rdata.
module log_ram
  import log_mem_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_LOG_DATA,
  parameter int NB_ADDR = NB_LOG_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic               re,
  input  logic [NB_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  // The array itself is never reset so it maps onto block RAM.
  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register carries a sync reset, which block RAM output
  // registers support natively.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/log_mem_ctrl.sv
// Capture/readback controller: fills the log RAM from valid samples after
// a run pulse, flags full after the last address, then serves reads.
// Latency: sample written at its edge; readback 1 cycle; no backpressure.
// Ports: clock, reset (sync, active-high), bus (log_mem_ctrl_if.slave).
module log_mem_ctrl
  import log_mem_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_LOG_DATA,
  parameter int NB_ADDR = NB_LOG_ADDR
) (
  input  logic           clock,
  input  logic           reset,
  log_mem_ctrl_if.slave  bus
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR:0]   DEPTH     = {1'b1, {NB_ADDR{1'b0}}};

  log_state_t         state, state_next;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR:0]   wr_count;
  logic               we;
  logic               ptr_clr;
  logic               re;

  // Next-state / write-enable decode. A run pulse overrides everything,
  // including a write landing on the last address.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    ptr_clr    = 1'b0;
    if (bus.i_run) begin
      state_next = CAPTURE;
      ptr_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        CAPTURE: begin
          if (bus.i_valid) begin
            we = 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              state_next = FULL;
            end
          end
        end
        FULL: begin
          state_next = FULL;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      state <= state_next;
      if (ptr_clr) begin
        wr_ptr   <= '0;
        wr_count <= '0;
      end else if (we) begin
        // Pointer wraps to 0 on the last write; the count stops at depth.
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_count != DEPTH) begin
          wr_count <= wr_count + 1'b1;
        end
      end
    end
  end

  // Reads only while frozen in FULL; otherwise the read register holds.
  assign re = (state == FULL) && bus.i_read;

  log_ram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_log_ram (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (bus.i_data),
    .re    (re),
    .raddr (bus.i_rd_addr),
    .rdata (bus.o_data)
  );

  assign bus.o_capturing = (state == CAPTURE);
  assign bus.o_mem_full  = (state == FULL);
  assign bus.o_wr_count  = wr_count;

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Directed bench for log_mem_ctrl at NB_ADDR=4 (depth 16).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_log_mem_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  log_mem_ctrl_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  log_mem_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_run();
    bus.i_run = 1'b1;
    tick();
    bus.i_run = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.o_capturing !== 1'b0) begin miscompares++; $display("FAIL reset_capturing got %0b exp 0", bus.o_capturing); end
    vectors++;
    if (bus.o_mem_full !== 1'b0) begin miscompares++; $display("FAIL reset_mem_full got %0b exp 0", bus.o_mem_full); end
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL reset_wr_count got %0d exp 0", bus.o_wr_count); end
    vectors++;
    if (bus.o_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h exp 0", bus.o_data); end
    reset = 1'b0;
    // Samples without a run pulse must be ignored.
    for (int n = 0; n < 20; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'hA5A5_0000 + n;
      tick();
    end
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL idle_wr_count got %0d exp 0", bus.o_wr_count); end
    vectors++;
    if (bus.o_mem_full !== 1'b0) begin miscompares++; $display("FAIL idle_mem_full got %0b exp 0", bus.o_mem_full); end
    vectors++;
    if (bus.o_capturing !== 1'b0) begin miscompares++; $display("FAIL idle_capturing got %0b exp 0", bus.o_capturing); end
    bus.i_read = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.i_rd_addr = 4'(a);
      tick();
      vectors++;
      if (bus.o_data !== 32'h0) begin miscompares++; $display("FAIL idle_read addr %0d got %h exp 0", a, bus.o_data); end
    end
    bus.i_read = 1'b0;
  endtask

  task automatic test_full_capture();
    // A sample presented on the run edge itself must not be logged.
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hDEAD_BEEF;
    pulse_run();
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_capturing !== 1'b1) begin miscompares++; $display("FAIL run_capturing got %0b exp 1", bus.o_capturing); end
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL run_wr_count got %0d exp 0", bus.o_wr_count); end
    for (int n = 0; n < 16; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h100 + n;
      tick();
      vectors++;
      if (bus.o_wr_count !== 5'(n + 1)) begin miscompares++; $display("FAIL fill_wr_count n=%0d got %0d exp %0d", n, bus.o_wr_count, n + 1); end
      vectors++;
      if (bus.o_mem_full !== (n == 15)) begin miscompares++; $display("FAIL fill_mem_full n=%0d got %0b exp %0b", n, bus.o_mem_full, n == 15); end
    end
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_capturing !== 1'b0) begin miscompares++; $display("FAIL full_capturing got %0b exp 0", bus.o_capturing); end
    bus.i_read = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.i_rd_addr = 4'(a);
      tick();
      vectors++;
      if (bus.o_data !== 32'h100 + a) begin miscompares++; $display("FAIL full_read addr %0d got %h exp %h", a, bus.o_data, 32'h100 + a); end
    end
    // With read disabled the output word holds.
    bus.i_read    = 1'b0;
    bus.i_rd_addr = 4'd3;
    tick();
    vectors++;
    if (bus.o_data !== 32'h10F) begin miscompares++; $display("FAIL read_hold got %h exp 0000010f", bus.o_data); end
  endtask

  task automatic test_gapped_valid();
    pulse_run();
    // Valid on odd cycles: 16th sample lands on the 32nd edge.
    for (int c = 0; c < 32; c++) begin
      bus.i_valid = (c % 2 == 1);
      bus.i_data  = (c % 2 == 1) ? 32'h300 + c / 2 : 32'hFFFF_0000 + c;
      tick();
      if (c == 30) begin
        vectors++;
        if (bus.o_mem_full !== 1'b0) begin miscompares++; $display("FAIL gap_early_full got %0b exp 0", bus.o_mem_full); end
        vectors++;
        if (bus.o_wr_count !== 5'd15) begin miscompares++; $display("FAIL gap_count15 got %0d exp 15", bus.o_wr_count); end
      end
    end
    vectors++;
    if (bus.o_mem_full !== 1'b1) begin miscompares++; $display("FAIL gap_full got %0b exp 1", bus.o_mem_full); end
    // Extra sample after full must be dropped.
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hBAD0_BAD0;
    tick();
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_wr_count !== 5'd16) begin miscompares++; $display("FAIL gap_extra_count got %0d exp 16", bus.o_wr_count); end
    vectors++;
    if (bus.o_mem_full !== 1'b1) begin miscompares++; $display("FAIL gap_extra_full got %0b exp 1", bus.o_mem_full); end
    bus.i_read = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.i_rd_addr = 4'(a);
      tick();
      vectors++;
      if (bus.o_data !== 32'h300 + a) begin miscompares++; $display("FAIL gap_read addr %0d got %h exp %h", a, bus.o_data, 32'h300 + a); end
    end
    bus.i_read = 1'b0;
  endtask

  task automatic test_restart();
    pulse_run();
    for (int n = 0; n < 7; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h400 + n;
      tick();
    end
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_wr_count !== 5'd7) begin miscompares++; $display("FAIL restart_pre_count got %0d exp 7", bus.o_wr_count); end
    pulse_run();
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL restart_clear got %0d exp 0", bus.o_wr_count); end
    vectors++;
    if (bus.o_capturing !== 1'b1) begin miscompares++; $display("FAIL restart_capturing got %0b exp 1", bus.o_capturing); end
    for (int n = 0; n < 16; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h200 + n;
      tick();
      if (n == 14) begin
        vectors++;
        if (bus.o_mem_full !== 1'b0) begin miscompares++; $display("FAIL restart_early_full got %0b exp 0", bus.o_mem_full); end
      end
    end
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_mem_full !== 1'b1) begin miscompares++; $display("FAIL restart_full got %0b exp 1", bus.o_mem_full); end
    bus.i_read    = 1'b1;
    bus.i_rd_addr = 4'd0;
    tick();
    vectors++;
    if (bus.o_data !== 32'h200) begin miscompares++; $display("FAIL restart_addr0 got %h exp 00000200", bus.o_data); end
    bus.i_rd_addr = 4'd15;
    tick();
    vectors++;
    if (bus.o_data !== 32'h20F) begin miscompares++; $display("FAIL restart_addr15 got %h exp 0000020f", bus.o_data); end
    bus.i_read = 1'b0;
  endtask

  task automatic test_collision();
    pulse_run();
    for (int n = 0; n < 15; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h500 + n;
      tick();
    end
    // Run coincides with the last write: restart wins.
    bus.i_data = 32'h5FF;
    bus.i_run  = 1'b1;
    tick();
    bus.i_run   = 1'b0;
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_mem_full !== 1'b0) begin miscompares++; $display("FAIL collide_full got %0b exp 0", bus.o_mem_full); end
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL collide_count got %0d exp 0", bus.o_wr_count); end
    vectors++;
    if (bus.o_capturing !== 1'b1) begin miscompares++; $display("FAIL collide_capturing got %0b exp 1", bus.o_capturing); end
  endtask

  task automatic test_reset_mid_capture();
    // Reads during CAPTURE must leave the last readback word untouched.
    bus.i_read    = 1'b1;
    bus.i_rd_addr = 4'd0;
    for (int n = 0; n < 5; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h700 + n;
      tick();
      vectors++;
      if (bus.o_data !== 32'h20F) begin miscompares++; $display("FAIL capture_read_hold n=%0d got %h exp 0000020f", n, bus.o_data); end
    end
    bus.i_valid = 1'b0;
    bus.i_read  = 1'b0;
    vectors++;
    if (bus.o_wr_count !== 5'd5) begin miscompares++; $display("FAIL mid_count got %0d exp 5", bus.o_wr_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.o_capturing !== 1'b0) begin miscompares++; $display("FAIL mid_reset_capturing got %0b exp 0", bus.o_capturing); end
    vectors++;
    if (bus.o_mem_full !== 1'b0) begin miscompares++; $display("FAIL mid_reset_full got %0b exp 0", bus.o_mem_full); end
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL mid_reset_count got %0d exp 0", bus.o_wr_count); end
    vectors++;
    if (bus.o_data !== 32'h0) begin miscompares++; $display("FAIL mid_reset_data got %h exp 0", bus.o_data); end
    // Further samples stay ignored until a new run.
    bus.i_valid = 1'b1;
    tick();
    tick();
    bus.i_valid = 1'b0;
    vectors++;
    if (bus.o_wr_count !== 5'd0) begin miscompares++; $display("FAIL post_reset_count got %0d exp 0", bus.o_wr_count); end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.i_run     = 1'b0;
    bus.i_read    = 1'b0;
    bus.i_rd_addr = '0;
    bus.i_data    = '0;
    bus.i_valid   = 1'b0;
    test_reset();
    test_full_capture();
    test_gapped_valid();
    test_restart();
    test_collision();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
